dm9000a_tx_engine: RTL and testbench
====================================

# dm9000a_tx_engine

Downstream of the Ethernet frame sender. It takes the 16-bit frame word stream and the request/complete handshake from that sender. It moves each word into the DM9000A TX SRAM through the shared register-command interface, then programs the frame length and issues TXREQ. It polls the controller until the transmit finishes and reports completion upstream.

## Interface
Parameters:
- MAX_WORDS, 757: maximum words stored per frame; 1514 bytes.
- POLL_LIMIT, 4095: maximum TCR polls before the engine gives up.

Ports:
- Clock  in  1  system clock.
- Reset_n  in  1  reset, asynchronous and active-low.
- tx_req_in  in  1  frame request; stays high while words remain, low after the last word.
- tx_packet_data_in  in  16  current frame word.
- tx_packet_data_rdy_out  out  1  one-cycle strobe; the word is consumed this cycle.
- tx_complete_out  out  1  one-cycle pulse when the frame is finished.
- tx_error_out  out  1  one-cycle pulse with tx_complete_out when the frame overflowed or the poll timed out.
- reg_req_out  out  1  requests ownership of the register interface.
- reg_grant_in  in  1  ownership granted.
- enet_rdy_in  in  1  register interface idle; the previous command is done.
- reg_start_comm_out  out  1  one-cycle command start.
- reg_addr_out  out  8  command register index.
- reg_dataw_out  out  16  command write data.
- reg_comm_type_out  out  2  command type: READ 0, WRITE 1, TX 2, RX 3.
- reg_post_command_delay  out  3  delay after the command: NO 0, STD 1, LONG 2.
- reg_datar_in  in  16  read data; valid once enet_rdy_in is high after a READ.

## Operation
- States: IDLE, GRANT, GAP, RDY, DATA, ISSUE_DATA, ISSUE_LENL, ISSUE_LENH, ISSUE_TXREQ, ISSUE_POLL, CHECK_POLL, DONE.
- The return register `ret` selects the state RDY exits to.
- IDLE: clear word_cnt, poll_cnt and ovf. If tx_req_in is high, go to GRANT.
- GRANT: reg_req_out stays high from here until DONE. When reg_grant_in is high, set ret=DATA and go to RDY.
- Every ISSUE_* state runs the same handshake:
  - pulse reg_start_comm_out for one cycle;
  - go to GAP for one cycle, then RDY;
  - RDY waits for enet_rdy_in=1, then goes to ret.
- Command fields (addr, dataw, type, delay) are registered. They are held from the ISSUE cycle until the next ISSUE.
- DATA, tx_req_in=1:
  - strobe tx_packet_data_rdy_out;
  - if word_cnt<MAX_WORDS: latch the word, increment word_cnt, go to ISSUE_DATA;
  - otherwise: discard the word, set ovf, stay in DATA.
- DATA, tx_req_in=0: go to ISSUE_LENL.
- ISSUE_DATA: type TX, addr 0xF8 (MWCMD), data = latched word, delay NO. Sets ret=DATA.
- Byte count is word_cnt<<1, 11 bits; odd lengths are impossible.
- ISSUE_LENL: WRITE, addr 0xFC, data {8'h00, bytes[7:0]}.
- ISSUE_LENH: WRITE, addr 0xFD, data {13'h0, bytes[10:8]}.
- ISSUE_TXREQ: WRITE, addr 0x02 (TCR), data 16'h0001, delay STD.
- ISSUE_POLL: READ, addr 0x02, delay NO. Sets ret=CHECK_POLL.
- CHECK_POLL:
  - reg_datar_in[0]=0: go to DONE;
  - otherwise increment poll_cnt;
  - poll_cnt reaches POLL_LIMIT: set a timeout flag, go to DONE;
  - else go to ISSUE_POLL.
- Zero-word frame (tx_req_in drops before the first DATA): skip LENL, LENH and TXREQ, go straight to DONE with no error.
- DONE:
  - pulse tx_complete_out;
  - tx_error_out = ovf OR timeout;
  - drop reg_req_out;
  - go to IDLE.
- Loss of reg_grant_in mid-frame is not supported. The arbiter holds the grant while reg_req_out is high.

## Timing
- Reset values (Reset_n low, asynchronous): state IDLE. Every output is 0; comm_type READ, delay NO.
- IDLE to GRANT takes 1 cycle after tx_req_in rises.
- Per word takes at least 4 cycles (DATA, ISSUE, GAP, RDY) plus any cycles enet_rdy_in stays low.
- tx_packet_data_rdy_out coincides with the cycle in which tx_packet_data_in is sampled. Upstream advances its word on the same edge.
- The end-of-frame sequence is 3 writes plus at least 1 poll, then DONE.
- tx_complete_out rises 1 cycle after CHECK_POLL sees bit0=0.
- tx_req_in rising while not in IDLE is ignored until DONE returns to IDLE.

## Structure
- Shared package dm9000a_pkg holds:
  - command-type codes and delay codes;
  - register indices MWCMD 0xF8, TXPLL 0xFC, TXPLH 0xFD, TCR 0x02, NSR 0x01;
  - the state enum.
- One natural sub-module, dm9000a_cmd_issuer: the ISSUE/GAP/RDY handshake with registered command fields, and a done strobe back to the engine.

## Test plan
- Grant after 3 cycles, enet_rdy responding immediately, 30 words 0x0001..0x001E:
  - 30 TX commands to 0xF8 with matching data;
  - writes 0xFC=0x3C, 0xFD=0x00, 0x02=0x0001;
  - TCR reads 1,1,0, then tx_complete_out pulses once with tx_error_out=0.
- 757-word frame: 0xFC=0xEA, 0xFD=0x05.
- 760-word frame: only 757 TX commands; all 760 data_rdy strobes; tx_error_out=1 at completion.
- enet_rdy_in held low 10 cycles after each start: no second start while low; word order preserved.
- TCR bit0 stuck at 1 with POLL_LIMIT=8: exactly 8 polls, then complete and error both pulse.
- Reset_n asserted mid-ISSUE_DATA: all outputs 0 at once; next frame runs cleanly from IDLE.

Source files
------------

// File: rtl/dm9000a_pkg.sv
// Shared definitions for the DM9000A register-command path: command/delay codes,
// register indices and the TX engine state encoding.
package dm9000a_pkg;

    typedef enum logic [1:0] {
        CMD_READ  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_TX    = 2'd2,
        CMD_RX    = 2'd3
    } comm_type_t;

    typedef enum logic [2:0] {
        DLY_NO   = 3'd0,
        DLY_STD  = 3'd1,
        DLY_LONG = 3'd2
    } post_delay_t;

    localparam logic [7:0] REG_NSR   = 8'h01;
    localparam logic [7:0] REG_TCR   = 8'h02;
    localparam logic [7:0] REG_MWCMD = 8'hF8;
    localparam logic [7:0] REG_TXPLL = 8'hFC;
    localparam logic [7:0] REG_TXPLH = 8'hFD;

    typedef enum logic [3:0] {
        IDLE,
        GRANT,
        GAP,
        RDY,
        DATA,
        ISSUE_DATA,
        ISSUE_LENL,
        ISSUE_LENH,
        ISSUE_TXREQ,
        ISSUE_POLL,
        CHECK_POLL,
        DONE
    } tx_state_t;

    typedef enum logic [1:0] {
        ISS_IDLE,
        ISS_START,
        ISS_GAP,
        ISS_WAIT
    } issue_state_t;

    typedef struct packed {
        comm_type_t  comm_type;
        logic [7:0]  addr;
        logic [15:0] dataw;
        post_delay_t delay;
    } reg_cmd_t;

endpackage

// File: rtl/dm9000a_tx_engine_if.sv
// Register-command bus between a DM9000A client (master) and the shared
// register interface / arbiter (slave).
interface dm9000a_tx_engine_if;

    logic        reg_req;
    logic        reg_grant;
    logic        enet_rdy;
    logic        reg_start_comm;
    logic [7:0]  reg_addr;
    logic [15:0] reg_dataw;
    logic [1:0]  reg_comm_type;
    logic [2:0]  reg_post_command_delay;
    logic [15:0] reg_datar;

    modport master (
        output reg_req,
        output reg_start_comm,
        output reg_addr,
        output reg_dataw,
        output reg_comm_type,
        output reg_post_command_delay,
        input  reg_grant,
        input  enet_rdy,
        input  reg_datar
    );

    modport slave (
        input  reg_req,
        input  reg_start_comm,
        input  reg_addr,
        input  reg_dataw,
        input  reg_comm_type,
        input  reg_post_command_delay,
        output reg_grant,
        output enet_rdy,
        output reg_datar
    );

endinterface

// File: rtl/dm9000a_cmd_issuer.sv
// Start/gap/wait handshake for one register command; the command fields are held
// in registers from the start cycle until the next launch.
module dm9000a_cmd_issuer
    import dm9000a_pkg::*;
(
    input  logic     Clock,
    input  logic     Reset_n,
    input  logic     launch,
    input  reg_cmd_t cmd,
    input  logic     enet_rdy,
    output logic     start_comm,
    output reg_cmd_t cmd_q,
    output logic     cmd_done
);

    issue_state_t state;
    issue_state_t state_next;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ISS_IDLE;
            cmd_q <= '0;
        end else begin
            state <= state_next;
            if (launch) begin
                cmd_q <= cmd;
            end
        end
    end

    // The gap cycle lets the controller drop enet_rdy before it is looked at again.
    always_comb begin
        state_next = state;
        cmd_done   = 1'b0;
        case (state)
            ISS_IDLE:  cmd_done = enet_rdy;
            ISS_START: state_next = ISS_GAP;
            ISS_GAP:   state_next = ISS_WAIT;
            ISS_WAIT: begin
                if (enet_rdy) begin
                    cmd_done   = 1'b1;
                    state_next = ISS_IDLE;
                end
            end
            default:   state_next = ISS_IDLE;
        endcase
        if (launch) begin
            state_next = ISS_START;
        end
    end

    assign start_comm = (state == ISS_START);

endmodule

// File: rtl/dm9000a_tx_engine.sv
// Copies an upstream frame into the DM9000A TX SRAM word by word, programs the
// length, issues TXREQ and polls TCR until the controller reports completion.
module dm9000a_tx_engine
    import dm9000a_pkg::*;
#(
    parameter int MAX_WORDS  = 757,
    parameter int POLL_LIMIT = 4095
) (
    input  logic                       Clock,
    input  logic                       Reset_n,
    input  logic                       tx_req_in,
    input  logic [15:0]                tx_packet_data_in,
    output logic                       tx_packet_data_rdy_out,
    output logic                       tx_complete_out,
    output logic                       tx_error_out,
    dm9000a_tx_engine_if.master        bus
);

    localparam int WW = $clog2(MAX_WORDS + 1);
    localparam int PW = $clog2(POLL_LIMIT + 1);

    tx_state_t   state;
    tx_state_t   state_next;
    tx_state_t   ret;
    logic [WW-1:0] word_cnt;
    logic [PW-1:0] poll_cnt;
    logic        ovf;
    logic        timeout;
    logic        word_inc;
    logic        ovf_set;
    logic        poll_inc;
    logic        timeout_set;
    logic        launch;
    logic        cmd_done;
    reg_cmd_t    cmd;
    reg_cmd_t    cmd_q;
    logic [10:0] byte_cnt;

    assign byte_cnt = 11'(word_cnt) << 1;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            ret      <= IDLE;
            word_cnt <= '0;
            poll_cnt <= '0;
            ovf      <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    word_cnt <= '0;
                    poll_cnt <= '0;
                    ovf      <= 1'b0;
                    timeout  <= 1'b0;
                end
                GRANT:       ret <= DATA;
                ISSUE_DATA:  ret <= DATA;
                ISSUE_LENL:  ret <= ISSUE_LENH;
                ISSUE_LENH:  ret <= ISSUE_TXREQ;
                ISSUE_TXREQ: ret <= ISSUE_POLL;
                ISSUE_POLL:  ret <= CHECK_POLL;
                default: ;
            endcase
            if (word_inc) begin
                word_cnt <= word_cnt + WW'(1);
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end
            if (poll_inc) begin
                poll_cnt <= poll_cnt + PW'(1);
            end
            if (timeout_set) begin
                timeout <= 1'b1;
            end
        end
    end

    // Words beyond MAX_WORDS are still acknowledged so upstream drains the frame.
    always_comb begin
        state_next             = state;
        tx_packet_data_rdy_out = 1'b0;
        tx_complete_out        = 1'b0;
        tx_error_out           = 1'b0;
        word_inc               = 1'b0;
        ovf_set                = 1'b0;
        poll_inc               = 1'b0;
        timeout_set            = 1'b0;
        case (state)
            IDLE:  if (tx_req_in) state_next = GRANT;
            GRANT: if (bus.reg_grant) state_next = RDY;
            GAP:   state_next = RDY;
            RDY:   if (cmd_done) state_next = ret;
            DATA: begin
                if (tx_req_in) begin
                    tx_packet_data_rdy_out = 1'b1;
                    if (word_cnt < WW'(MAX_WORDS)) begin
                        word_inc   = 1'b1;
                        state_next = ISSUE_DATA;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end else if (word_cnt == '0) begin
                    state_next = DONE;
                end else begin
                    state_next = ISSUE_LENL;
                end
            end
            ISSUE_DATA, ISSUE_LENL, ISSUE_LENH, ISSUE_TXREQ, ISSUE_POLL: state_next = GAP;
            CHECK_POLL: begin
                if (!bus.reg_datar[0]) begin
                    state_next = DONE;
                end else begin
                    poll_inc = 1'b1;
                    if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
                        timeout_set = 1'b1;
                        state_next  = DONE;
                    end else begin
                        state_next = ISSUE_POLL;
                    end
                end
            end
            DONE: begin
                tx_complete_out = 1'b1;
                tx_error_out    = ovf | timeout;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Command fields are loaded on the edge entering an ISSUE state so they are valid with the start pulse.
    always_comb begin
        launch = 1'b0;
        cmd    = '{comm_type: CMD_READ, addr: 8'h00, dataw: 16'h0000, delay: DLY_NO};
        case (state_next)
            ISSUE_DATA: begin
                launch = 1'b1;
                cmd    = '{comm_type: CMD_TX, addr: REG_MWCMD, dataw: tx_packet_data_in, delay: DLY_NO};
            end
            ISSUE_LENL: begin
                launch = 1'b1;
                cmd    = '{comm_type: CMD_WRITE, addr: REG_TXPLL, dataw: {8'h00, byte_cnt[7:0]}, delay: DLY_NO};
            end
            ISSUE_LENH: begin
                launch = 1'b1;
                cmd    = '{comm_type: CMD_WRITE, addr: REG_TXPLH, dataw: {13'h0000, byte_cnt[10:8]}, delay: DLY_NO};
            end
            ISSUE_TXREQ: begin
                launch = 1'b1;
                cmd    = '{comm_type: CMD_WRITE, addr: REG_TCR, dataw: 16'h0001, delay: DLY_STD};
            end
            ISSUE_POLL: begin
                launch = 1'b1;
                cmd    = '{comm_type: CMD_READ, addr: REG_TCR, dataw: 16'h0000, delay: DLY_NO};
            end
            default: ;
        endcase
    end

    dm9000a_cmd_issuer u_issuer (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .launch     (launch),
        .cmd        (cmd),
        .enet_rdy   (bus.enet_rdy),
        .start_comm (bus.reg_start_comm),
        .cmd_q      (cmd_q),
        .cmd_done   (cmd_done)
    );

    assign bus.reg_req                = (state != IDLE) && (state != DONE);
    assign bus.reg_addr               = cmd_q.addr;
    assign bus.reg_dataw              = cmd_q.dataw;
    assign bus.reg_comm_type          = cmd_q.comm_type;
    assign bus.reg_post_command_delay = cmd_q.delay;

endmodule

// File: tb/tb_dm9000a_tx_engine.sv
// Scoreboard bench for dm9000a_tx_engine: expected commands and completions are queued
// by the stimulus and consumed by a register-bus monitor/responder.
module tb_dm9000a_tx_engine;

    localparam int MAX_WORDS  = 757;
    localparam int POLL_LIMIT = 8;

    localparam logic [1:0] TY_READ  = 2'd0;
    localparam logic [1:0] TY_WRITE = 2'd1;
    localparam logic [1:0] TY_TX    = 2'd2;
    localparam logic [2:0] DL_NO    = 3'd0;
    localparam logic [2:0] DL_STD   = 3'd1;

    typedef struct packed {
        logic [1:0]  ty;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [2:0]  dly;
    } exp_cmd_t;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        tx_req_in = 1'b0;
    logic [15:0] tx_packet_data_in = 16'h0000;
    logic        tx_packet_data_rdy_out;
    logic        tx_complete_out;
    logic        tx_error_out;

    int       vectors = 0;
    int       miscompares = 0;
    exp_cmd_t exp_q[$];
    logic     done_q[$];
    int       busy_cycles = 0;
    int       busy_cnt = 0;
    int       zero_at = 1;
    int       poll_num = 0;
    int       grant_cnt = 0;

    dm9000a_tx_engine_if bus ();

    dm9000a_tx_engine #(
        .MAX_WORDS  (MAX_WORDS),
        .POLL_LIMIT (POLL_LIMIT)
    ) dut (
        .Clock                  (Clock),
        .Reset_n                (Reset_n),
        .tx_req_in              (tx_req_in),
        .tx_packet_data_in      (tx_packet_data_in),
        .tx_packet_data_rdy_out (tx_packet_data_rdy_out),
        .tx_complete_out        (tx_complete_out),
        .tx_error_out           (tx_error_out),
        .bus                    (bus)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic push_cmd(input logic [1:0] ty, input logic [7:0] addr, input logic [15:0] data, input logic [2:0] dly);
        exp_cmd_t e;
        e.ty   = ty;
        e.addr = addr;
        e.data = data;
        e.dly  = dly;
        exp_q.push_back(e);
    endtask

    // Arbiter, controller model and monitor share the falling edge, away from the DUT's active edge.
    always @(negedge Clock) begin
        exp_cmd_t e;
        exp_cmd_t got;
        if (!Reset_n) begin
            bus.reg_grant = 1'b0;
            bus.enet_rdy  = 1'b1;
            grant_cnt     = 0;
            busy_cnt      = 0;
        end else begin
            if (!bus.reg_req) begin
                bus.reg_grant = 1'b0;
                grant_cnt     = 0;
            end else if (!bus.reg_grant) begin
                grant_cnt++;
                if (grant_cnt >= 3) bus.reg_grant = 1'b1;
            end
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) bus.enet_rdy = 1'b1;
            end
            if (bus.reg_start_comm) begin
                checkOutput("start_while_busy", 64'(bus.enet_rdy), 64'd1);
                got.ty   = bus.reg_comm_type;
                got.addr = bus.reg_addr;
                got.data = bus.reg_dataw;
                got.dly  = bus.reg_post_command_delay;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL cmd_extra: got %h, expected no command", got);
                end else begin
                    e = exp_q.pop_front();
                    if (e.ty == TY_READ) got.data = 16'h0000;
                    checkOutput("cmd", 64'(got), 64'(e));
                end
                if (bus.reg_comm_type == TY_READ) begin
                    poll_num++;
                    bus.reg_datar = (zero_at != 0 && poll_num == zero_at) ? 16'h0040 : 16'h0041;
                end
                if (busy_cycles > 0) begin
                    bus.enet_rdy = 1'b0;
                    busy_cnt     = busy_cycles;
                end
            end
            if (tx_complete_out) begin
                if (done_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL complete_extra: got complete pulse, expected none");
                end else begin
                    checkOutput("complete_error", 64'(tx_error_out), 64'(done_q.pop_front()));
                end
            end else if (tx_error_out) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL error_alone: got tx_error_out=1, expected 0 outside completion");
            end
        end
    end

    // Queue the expected command stream, then play the frame with the word advancing on each strobe.
    task automatic applyStimulus(input int n, input logic [15:0] base, input int busy, input int z_at);
        int          stored;
        int          polls;
        int          idx;
        int          guard;
        int          strobes;
        logic        strobe;
        logic        exp_err;
        logic [10:0] bytes;
        busy_cycles = busy;
        zero_at     = z_at;
        poll_num    = 0;
        stored      = (n > MAX_WORDS) ? MAX_WORDS : n;
        for (int i = 0; i < stored; i++) push_cmd(TY_TX, 8'hF8, base + 16'(i), DL_NO);
        exp_err = 1'b0;
        if (n > 0) begin
            bytes = 11'(stored * 2);
            push_cmd(TY_WRITE, 8'hFC, {8'h00, bytes[7:0]}, DL_NO);
            push_cmd(TY_WRITE, 8'hFD, {13'h0000, bytes[10:8]}, DL_NO);
            push_cmd(TY_WRITE, 8'h02, 16'h0001, DL_STD);
            polls = (z_at != 0 && z_at <= POLL_LIMIT) ? z_at : POLL_LIMIT;
            for (int i = 0; i < polls; i++) push_cmd(TY_READ, 8'h02, 16'h0000, DL_NO);
            exp_err = (n > MAX_WORDS) || !(z_at != 0 && z_at <= POLL_LIMIT);
        end
        done_q.push_back(exp_err);

        strobes           = 0;
        idx               = 0;
        guard             = 0;
        tx_req_in         = 1'b1;
        tx_packet_data_in = base;
        if (n == 0) begin
            @(posedge Clock);
            #1 tx_req_in = 1'b0;
        end
        while (idx < n && guard < 20000) begin
            @(negedge Clock);
            strobe = tx_packet_data_rdy_out;
            @(posedge Clock);
            #1;
            guard++;
            if (strobe) begin
                strobes++;
                idx++;
                if (idx < n) tx_packet_data_in = base + 16'(idx);
                else tx_req_in = 1'b0;
            end
        end
        tx_req_in = 1'b0;
        checkOutput("data_strobes", 64'(strobes), 64'(n));

        guard = 0;
        while (done_q.size() != 0 && guard < 20000) begin
            @(negedge Clock);
            #1;
            guard++;
        end
        checkOutput("completion_pending", 64'(done_q.size()), 64'd0);
        checkOutput("cmds_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        done_q.delete();
        repeat (3) @(negedge Clock);
    endtask

    initial begin
        int guard;
        bus.reg_datar = 16'h0000;
        repeat (3) @(negedge Clock);
        checkOutput("reset_outputs", 64'({tx_packet_data_rdy_out, tx_complete_out, tx_error_out,
                    bus.reg_req, bus.reg_start_comm, bus.reg_addr, bus.reg_dataw,
                    bus.reg_comm_type, bus.reg_post_command_delay}), 64'd0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clock);

        $display("[TB] 30-word frame, TCR busy twice");
        applyStimulus(30, 16'h0001, 0, 3);
        $display("[TB] maximum-length frame");
        applyStimulus(757, 16'h1000, 0, 1);
        $display("[TB] overflowing frame");
        applyStimulus(760, 16'h2000, 0, 1);
        $display("[TB] slow register interface");
        applyStimulus(8, 16'h3000, 10, 2);
        $display("[TB] TCR stuck busy");
        applyStimulus(5, 16'h4000, 0, 0);
        $display("[TB] zero-word frame");
        applyStimulus(0, 16'h0000, 0, 1);

        $display("[TB] reset during a data command");
        busy_cycles       = 0;
        zero_at           = 1;
        push_cmd(TY_TX, 8'hF8, 16'hBEEF, DL_NO);
        tx_packet_data_in = 16'hBEEF;
        tx_req_in         = 1'b1;
        guard             = 0;
        while (guard < 100) begin
            @(negedge Clock);
            #1;
            if (bus.reg_start_comm) break;
            guard++;
        end
        checkOutput("reached_issue_data", 64'(bus.reg_start_comm), 64'd1);
        Reset_n   = 1'b0;
        tx_req_in = 1'b0;
        #1;
        checkOutput("async_reset_outputs", 64'({tx_packet_data_rdy_out, tx_complete_out, tx_error_out,
                    bus.reg_req, bus.reg_start_comm, bus.reg_addr, bus.reg_dataw,
                    bus.reg_comm_type, bus.reg_post_command_delay}), 64'd0);
        checkOutput("reset_cmds_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clock);
        applyStimulus(4, 16'h0A00, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
